// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Drives the CPU reset for a set number of cycles and then lets the core run
//   for a bounded number of cycles. While the core runs, every data_result sample
//   is folded into a rotate-left-by-one XOR signature. This repeats for NUM_RUNS
//   runs. Any run whose signature differs from run 0 raises a sticky mismatch.
//   A run can also end early when the result has held steady for STABLE_CYCLES
//   consecutive samples (0 disables this).
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous active-high reset
//   start           begins a sequence (honoured only in IDLE/DONE)
//   cpu_data_result CPU result bus, sampled every RUN cycle
//   cpu_reset       reset to the CPU, low only while running
//   busy            sequence in progress
//   done            sequence complete, held until the next start
//   run_index       current run number (0-based)
//   cycle_count     samples taken in the current/last run
//   signature       signature of the current/last run
//   ref_signature   signature of run 0
//   mismatch        sticky: some run's signature differed from run 0
//   halted          last run ended by stability rather than by RUN_CYCLES
module cpu_run_controller #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned RESET_CYCLES  = 2,
    parameter int unsigned RUN_CYCLES    = 10,
    parameter int unsigned NUM_RUNS      = 2,
    parameter int unsigned STABLE_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cpu_data_result,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic [7:0]        run_index,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] signature,
    output logic [DATA_W-1:0] ref_signature,
    output logic              mismatch,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT  = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
    localparam logic [7:0]       LAST_RUN   = 8'(NUM_RUNS - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   rst_cnt;
    logic [CNT_W-1:0]   stable;
    logic [DATA_W-1:0]  prev;

    logic               start_seq;
    logic               enter_reset;
    logic               reset_last;
    logic               last_run;
    logic               first_sample;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   stable_next;
    logic [DATA_W-1:0]  sig_next;
    logic               stable_hit;
    logic               run_exit;

    // Per-sample datapath values, shared by the next-state logic and the
    // register updates so the exit decision sees the same sample being folded.
    always_comb begin
        start_seq    = ((state == S_IDLE) || (state == S_DONE)) && start;
        reset_last   = (rst_cnt == RESET_LAST);
        last_run     = (run_index == LAST_RUN);
        first_sample = (cycle_count == '0);
        cnt_next     = cycle_count + CNT_W'(1);
        sig_next     = {signature[DATA_W-2:0], signature[DATA_W-1]} ^ cpu_data_result;
        stable_next  = (!first_sample && (cpu_data_result == prev)) ? stable + CNT_W'(1) : '0;
        stable_hit   = (STABLE_CYCLES != 0) && (stable_next == STABLE_LIM);
        run_exit     = (cnt_next == RUN_LIMIT) || stable_hit;
        enter_reset  = start_seq || ((state == S_CHECK) && !last_run);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RESET;
            S_RESET: if (reset_last) state_next = S_RUN;
            S_RUN:   if (run_exit) state_next = S_CHECK;
            S_CHECK: state_next = last_run ? S_DONE : S_RESET;
            S_DONE:  if (start) state_next = S_RESET;
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cpu_reset = (state != S_RUN);
        busy      = (state == S_RESET) || (state == S_RUN) || (state == S_CHECK);
        done      = (state == S_DONE);
    end

    // Run datapath: counters, signature and result flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_cnt       <= '0;
            stable        <= '0;
            prev          <= '0;
            run_index     <= '0;
            cycle_count   <= '0;
            signature     <= '0;
            ref_signature <= '0;
            mismatch      <= 1'b0;
            halted        <= 1'b0;
        end else begin
            if (start_seq) begin
                run_index <= '0;
                mismatch  <= 1'b0;
            end
            if (enter_reset) begin
                rst_cnt     <= '0;
                stable      <= '0;
                cycle_count <= '0;
                signature   <= '0;
                halted      <= 1'b0;
            end
            case (state)
                S_RESET: begin
                    rst_cnt <= rst_cnt + CNT_W'(1);
                end
                S_RUN: begin
                    cycle_count <= cnt_next;
                    signature   <= sig_next;
                    prev        <= cpu_data_result;
                    stable      <= stable_next;
                    if (run_exit) halted <= stable_hit;
                end
                S_CHECK: begin
                    if (run_index == '0) begin
                        ref_signature <= signature;
                    end else begin
                        mismatch <= mismatch | (signature != ref_signature);
                    end
                    if (!last_run) run_index <= run_index + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int RC = 2;
    localparam int RN = 5;
    localparam int NR = 2;
    localparam int SC = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] data  = '0;

    logic          cpu_reset, busy, done, mismatch, halted;
    logic [7:0]    run_index;
    logic [CW-1:0] cycle_count;
    logic [DW-1:0] signature, ref_signature;

    cpu_run_controller #(
        .DATA_W(DW), .CNT_W(CW), .RESET_CYCLES(RC), .RUN_CYCLES(RN),
        .NUM_RUNS(NR), .STABLE_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cpu_data_result(data),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .run_index(run_index),
        .cycle_count(cycle_count), .signature(signature), .ref_signature(ref_signature),
        .mismatch(mismatch), .halted(halted)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a sequence is a list of runs; each run is a countdown
    // of reset cycles, a list of samples, then one check cycle.
    bit m_active, m_done, m_check, m_halt, m_mis;
    int m_rleft, m_run, m_cnt, m_stable, m_sig, m_ref, m_prev;

    int mode = 0;
    logic [DW-1:0] feed0 [RN];
    logic [DW-1:0] feed1 [RN];
    logic [DW-1:0] pat   [8] = '{8'd3, 8'd5, 8'd5, 8'd5, 8'd9, 8'd1, 8'd1, 8'd2};

    function automatic int rotl8(int v);
        return ((v * 2) % 256) + (v / 128);
    endfunction

    function automatic bit m_running();
        return m_active && (m_rleft == 0) && !m_check;
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_check = 0; m_halt = 0; m_mis = 0;
        m_rleft = 0; m_run = 0; m_cnt = 0; m_stable = 0; m_sig = 0; m_ref = 0; m_prev = 0;
    endtask

    task automatic begin_run();
        m_rleft = RC; m_sig = 0; m_cnt = 0; m_stable = 0; m_halt = 0;
    endtask

    task automatic model_step();
        int d;
        bit hit;
        d = int'(data);
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_run = 0; m_mis = 0; m_halt = 0;
                begin_run();
            end
        end else if (m_rleft > 0) begin
            m_rleft--;
        end else if (m_check) begin
            m_check = 0;
            if (m_run == 0) m_ref = m_sig;
            else if (m_sig != m_ref) m_mis = 1;
            if (m_run == NR - 1) begin
                m_active = 0; m_done = 1;
            end else begin
                m_run++;
                begin_run();
            end
        end else begin
            m_stable = (m_cnt != 0 && d == m_prev) ? m_stable + 1 : 0;
            m_cnt++;
            m_sig  = rotl8(m_sig) ^ d;
            m_prev = d;
            hit = (SC > 0) && (m_stable == SC);
            if (m_cnt == RN || hit) begin
                m_check = 1;
                m_halt  = hit;
            end
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("cpu_reset", int'(cpu_reset), int'(!m_running()));
        check("busy", int'(busy), int'(m_active));
        check("done", int'(done), int'(m_done));
        check("run_index", int'(run_index), m_run);
        check("cycle_count", int'(cycle_count), m_cnt);
        check("signature", int'(signature), m_sig);
        check("ref_signature", int'(ref_signature), m_ref);
        check("mismatch", int'(mismatch), int'(m_mis));
        check("halted", int'(halted), int'(m_halt));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
        compare_all();
        if (mode == 0) begin
            if (m_running()) data = (m_run == 0) ? feed0[m_cnt] : feed1[m_cnt];
            else data = 8'hAA;
        end else begin
            if ($urandom_range(0, 7) != 0) data = pat[m_cnt % 8];
            else data = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_cpu_reset", int'(cpu_reset), 1);
        check("async_busy", int'(busy), 0);
        check("async_sig", int'(signature), 0);
        tick();
        #2 reset = 1'b0;
    endtask

    task automatic run_to_done(input int limit, output int edges, output int lows,
                               output int first_low, output int last_low);
        edges = 0; lows = 0; first_low = -1; last_low = -1;
        while (!done && edges < limit) begin
            tick();
            edges++;
            if (!cpu_reset) begin
                lows++;
                if (first_low < 0) first_low = edges;
                last_low = edges;
            end
        end
        check("done_reached", int'(done), 1);
    endtask

    task automatic set_feeds(input logic [DW-1:0] a [RN], input logic [DW-1:0] b [RN]);
        for (int i = 0; i < RN; i++) begin
            feed0[i] = a[i];
            feed1[i] = b[i];
        end
    endtask

    initial begin
        int edges, lows, fl, ll, guard;
        logic [DW-1:0] fa [RN];
        logic [DW-1:0] fb [RN];

        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_cpu_reset", int'(cpu_reset), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_signature", int'(signature), 0);

        // Determinism: runs differ in the last sample
        fa = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        fb = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        set_feeds(fa, fb);
        start = 1'b1; tick(); start = 1'b0;
        run_to_done(60, edges, lows, fl, ll);
        check("det_done_edge", edges, NR * (RC + RN + 1));
        check("det_low_cycles", lows, NR * RN);
        check("det_gap_high", (ll - fl + 1) - lows, RC + 1);
        check("det_ref", int'(ref_signature), 8'h10);
        check("det_sig", int'(signature), 8'h11);
        check("det_mismatch", int'(mismatch), 1);
        check("det_run_index", int'(run_index), 1);
        check("det_count", int'(cycle_count), 5);
        tick();

        // Early halt on three equal samples
        fa = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h07};
        set_feeds(fa, fa);
        start = 1'b1; tick(); start = 1'b0;
        run_to_done(60, edges, lows, fl, ll);
        check("halt_done_edge", edges, NR * (RC + 3 + 1));
        check("halt_count", int'(cycle_count), 3);
        check("halt_flag", int'(halted), 1);
        check("halt_sig", int'(signature), 8'h15);
        check("halt_mismatch", int'(mismatch), 0);

        // Stability reached on the final allowed sample
        fa = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03};
        set_feeds(fa, fa);
        start = 1'b1; tick(); start = 1'b0;
        run_to_done(60, edges, lows, fl, ll);
        check("tie_count", int'(cycle_count), 5);
        check("tie_halted", int'(halted), 1);
        check("tie_sig", int'(signature), 8'h09);

        // Start pulse during RUN is ignored
        fa = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        set_feeds(fa, fa);
        start = 1'b1; tick(); start = 1'b0;
        guard = 0;
        while (cpu_reset && guard < 20) begin tick(); guard++; end
        check("ign_run_entered", int'(cpu_reset), 0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        check("ign_run_index", int'(run_index), 0);
        check("ign_count", int'(cycle_count), 2);
        check("ign_busy", int'(busy), 1);
        run_to_done(60, edges, lows, fl, ll);
        check("ign_mismatch", int'(mismatch), 0);

        // Asynchronous reset during run 1
        start = 1'b1; tick(); start = 1'b0;
        guard = 0;
        while (!(run_index == 8'd1 && !cpu_reset) && guard < 40) begin tick(); guard++; end
        check("ar_in_run1", int'(run_index), 1);
        tick();
        async_reset();
        for (int i = 0; i < 5; i++) tick();
        check("ar_stays_idle", int'(busy), 0);
        check("ar_cpu_reset", int'(cpu_reset), 1);

        // Back-to-back starts: done lasts one cycle, results recomputed
        fb = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        set_feeds(fa, fb);
        start = 1'b1;
        tick();
        run_to_done(60, edges, lows, fl, ll);
        check("b2b_mismatch1", int'(mismatch), 1);
        set_feeds(fb, fb);
        tick();
        check("b2b_done_pulse", int'(done), 0);
        check("b2b_restart_busy", int'(busy), 1);
        run_to_done(60, edges, lows, fl, ll);
        start = 1'b0;
        check("b2b_ref", int'(ref_signature), 8'h11);
        check("b2b_mismatch2", int'(mismatch), 0);
        tick();

        // Randomized traffic against the model
        mode = 1;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick();
        end
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
